// File: rtl/pass_gate_arbiter.sv
// Purpose : round-robin owner selection for one shared drain node fed through N transmission gates,
//           with break-before-make dead time and an optional per-grant hold limit.
// Latency : one cycle from req to grant. Gates go off on the edge that samples the release or hold expiry.
//           Next owner's first on-cycle comes DEAD_CYCLES+1 cycles after the previous owner's last on-cycle.
// Backpressure : none. req is a level input. An owner keeps the drain until it drops req or MAX_HOLD expires.
//           Other requesters simply wait; there is no preemption.
// Ports   : clk, rst_n (async, active low); req[N] level requests;
//           grant/ngate[N] one-hot-or-zero owner (nmos on = 1); pgate[N] = ~ngate (pmos on = 0);
//           busy = a gate pair is on; owner = last granted index; timeout = 1-cycle hold-expiry pulse.
module pass_gate_arbiter #(
   parameter int N           = 4,
   parameter int DEAD_CYCLES = 2,
   parameter int MAX_HOLD    = 8,
   localparam int OW         = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  grant,
   output logic [N-1:0]  ngate,
   output logic [N-1:0]  pgate,
   output logic          busy,
   output logic [OW-1:0] owner,
   output logic          timeout
);

   localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam int DW = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_DEAD = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    grant_q, grant_d;
   logic [OW-1:0]   owner_q, owner_d;
   // First index searched at the next arbitration. It is owner+1 except after reset,
   // where it starts at 0 so source 0 has top priority.
   logic [OW-1:0]   ptr_q, ptr_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [DW-1:0]   dead_q, dead_d;
   logic            timeout_q, timeout_d;
   logic            busy_q, busy_d;

   logic            win_found;
   logic [OW-1:0]   win_idx;
   logic [OW-1:0]   scan_idx;

   // Round-robin search: first set request at or after ptr_q, wrapping at N-1.
   // The index arithmetic wraps modulo N, so a non-power-of-two N never aliases.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = '0;
      for (int i = 0; i < N; i++) begin
         scan_idx = OW'((int'(ptr_q) + i) % N);
         if (!win_found && req[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      dead_d    = dead_q;
      busy_d    = busy_q;
      timeout_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               state_d = ST_ON;
               grant_d = {{(N-1){1'b0}}, 1'b1} << win_idx;
               owner_d = win_idx;
               ptr_d   = (win_idx == OW'(N - 1)) ? '0 : win_idx + OW'(1);
               hold_d  = HW'(1);
               busy_d  = 1'b1;
            end
         end

         ST_ON: begin
            // A dropped request takes precedence over hold expiry, so a release on the
            // final allowed cycle is reported as a normal release without a timeout.
            if (!req[owner_q]) begin
               state_d = ST_DEAD;
               grant_d = '0;
               busy_d  = 1'b0;
               hold_d  = '0;
               dead_d  = DW'(1);
            end else if ((MAX_HOLD > 0) && (hold_q == HW'(MAX_HOLD))) begin
               state_d   = ST_DEAD;
               grant_d   = '0;
               busy_d    = 1'b0;
               hold_d    = '0;
               dead_d    = DW'(1);
               timeout_d = 1'b1;
            end else if (hold_q != '1) begin
               // Saturates, so a disabled hold limit cannot wrap the counter.
               hold_d = hold_q + HW'(1);
            end
         end

         ST_DEAD: begin
            if (dead_q == DW'(DEAD_CYCLES)) begin
               state_d = ST_IDLE;
               dead_d  = '0;
            end else begin
               dead_d = dead_q + DW'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
            hold_d  = '0;
            dead_d  = '0;
         end
      endcase
   end

   // The asynchronous clear drops the gates the moment rst_n falls, even mid-grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         owner_q   <= '0;
         ptr_q     <= '0;
         hold_q    <= '0;
         dead_q    <= '0;
         timeout_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         dead_q    <= dead_d;
         timeout_q <= timeout_d;
         busy_q    <= busy_d;
      end
   end

   // Every output is a flop or a straight copy or inversion of one; req never reaches an output combinationally.
   assign grant   = grant_q;
   assign ngate   = grant_q;
   assign pgate   = ~grant_q;
   assign busy    = busy_q;
   assign owner   = owner_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_pass_gate_arbiter.sv
// Purpose : directed checks of pass_gate_arbiter (N=4, DEAD_CYCLES=2, MAX_HOLD=8).
// Latency : inputs are driven and outputs sampled 1 time unit after each rising edge.
// Backpressure : not applicable; the bench drives req levels only.
module tb_pass_gate_arbiter;

   localparam int N  = 4;
   localparam int DC = 2;
   localparam int MH = 8;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] req;
   logic [N-1:0] grant;
   logic [N-1:0] ngate;
   logic [N-1:0] pgate;
   logic         busy;
   logic [1:0]   owner;
   logic         timeout;

   int checks = 0;
   int errors = 0;

   pass_gate_arbiter #(
      .N           (N),
      .DEAD_CYCLES (DC),
      .MAX_HOLD    (MH)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .grant   (grant),
      .ngate   (ngate),
      .pgate   (pgate),
      .busy    (busy),
      .owner   (owner),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Invariant monitor on the falling edge: gate complementarity, one owner at most,
   // and at least DC+1 all-off cycles between one gate falling and the next rising.
   int           gap = 100;
   logic [N-1:0] prev_ng = '0;
   logic [N-1:0] inv_ng;
   always @(negedge clk) begin
      inv_ng = ~ngate;
      chk("inv_pgate", pgate, inv_ng);
      chk("inv_onehot0", $onehot0(grant), 1);
      chk("inv_ngate_grant", ngate, grant);
      if (!rst_n) begin
         gap     = 100;
         prev_ng = '0;
      end else begin
         if (ngate != '0 && prev_ng == '0)
            chk("inv_dead_gap", (gap >= DC + 1), 1);
         if (ngate == '0)
            gap = (prev_ng != '0) ? 1 : gap + 1;
         prev_ng = ngate;
      end
   end

   logic [N-1:0] exp_g;
   logic [N-1:0] exp_p;
   int           own;

   initial begin
      // Reset held with all sources requesting.
      rst_n = 1'b0;
      req   = 4'b1111;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_grant",   grant,   0);
      chk("rst_ngate",   ngate,   0);
      chk("rst_pgate",   pgate,   4'b1111);
      chk("rst_busy",    busy,    0);
      chk("rst_owner",   owner,   0);
      chk("rst_timeout", timeout, 0);
      rst_n = 1'b1;

      // Full rotation under continuous requests: 8-cycle grants, timeout pulse, 3 off cycles.
      for (int k = 0; k < 5; k++) begin
         own   = k % N;
         exp_g = 4'b0001 << own;
         exp_p = ~exp_g;
         for (int c = 1; c <= MH; c++) begin
            tick;
            chk("rr_grant",   grant,   exp_g);
            chk("rr_pgate",   pgate,   exp_p);
            chk("rr_owner",   owner,   own);
            chk("rr_busy",    busy,    1);
            chk("rr_timeout", timeout, 0);
         end
         for (int d = 1; d <= DC + 1; d++) begin
            tick;
            chk("rr_gap_grant",   grant,   0);
            chk("rr_gap_busy",    busy,    0);
            chk("rr_gap_owner",   owner,   own);
            chk("rr_gap_timeout", timeout, (d == 1) ? 1 : 0);
         end
      end

      // Source 2 alone for 3 cycles, then drops: normal release, then idle.
      req = 4'b0100;
      for (int c = 1; c <= 3; c++) begin
         tick;
         chk("short_grant",   grant,   4'b0100);
         chk("short_timeout", timeout, 0);
      end
      req = 4'b0000;
      tick;
      chk("short_rel_grant",   grant,   0);
      chk("short_rel_timeout", timeout, 0);
      for (int c = 0; c < 6; c++) begin
         tick;
         chk("idle_busy",    busy,    0);
         chk("idle_grant",   grant,   0);
         chk("idle_timeout", timeout, 0);
         chk("idle_owner",   owner,   2);
      end

      // Source 2 alone, continuous: timed out, then regranted as sole requester.
      req = 4'b0100;
      for (int c = 1; c <= MH; c++) begin
         tick;
         chk("solo1_grant",   grant,   4'b0100);
         chk("solo1_timeout", timeout, 0);
      end
      tick;
      chk("solo_to_grant", grant,   0);
      chk("solo_to_pulse", timeout, 1);
      for (int d = 2; d <= DC + 1; d++) begin
         tick;
         chk("solo_gap_grant",   grant,   0);
         chk("solo_gap_timeout", timeout, 0);
      end
      for (int c = 1; c <= MH; c++) begin
         tick;
         chk("solo2_grant",   grant,   4'b0100);
         chk("solo2_timeout", timeout, 0);
      end
      // Request drops in the very cycle the hold limit is reached: no timeout.
      req = 4'b0000;
      tick;
      chk("edge_rel_grant",   grant,   0);
      chk("edge_rel_timeout", timeout, 0);
      repeat (DC) begin
         tick;
         chk("edge_gap_grant", grant, 0);
      end

      // Source 1 owns; requests switch to 1001 as it releases: source 3 wins.
      req = 4'b0010;
      tick;
      chk("s1_grant", grant, 4'b0010);
      chk("s1_owner", owner, 1);
      tick;
      chk("s1_grant2", grant, 4'b0010);
      req = 4'b1001;
      tick;
      chk("s1_rel_grant",   grant,   0);
      chk("s1_rel_timeout", timeout, 0);
      repeat (DC) begin
         tick;
         chk("s1_gap_grant", grant, 0);
      end
      tick;
      chk("rr_from2_grant", grant, 4'b1000);
      chk("rr_from2_owner", owner, 3);

      // Get source 1 on again, then assert reset mid-cycle.
      req = 4'b0010;
      tick;
      chk("s3_rel_grant", grant, 0);
      repeat (DC) begin
         tick;
         chk("s3_gap_grant", grant, 0);
      end
      tick;
      chk("s1b_grant", grant, 4'b0010);
      tick;
      chk("s1b_grant2", grant, 4'b0010);
      #3;
      rst_n = 1'b0;
      #2;
      chk("midrst_ngate", ngate,   0);
      chk("midrst_pgate", pgate,   4'b1111);
      chk("midrst_grant", grant,   0);
      chk("midrst_busy",  busy,    0);
      chk("midrst_owner", owner,   0);
      chk("midrst_to",    timeout, 0);
      req = 4'b1111;
      tick;
      rst_n = 1'b1;
      tick;
      chk("post_rst_grant", grant, 4'b0001);
      chk("post_rst_pgate", pgate, 4'b1110);
      chk("post_rst_owner", owner, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pass_gate_arbiter.md
Name: pass_gate_arbiter

Overview:
- Round-robin arbiter that shares one drain node between N sources.
- Each source connects to the drain through a transmission gate: an nmos with an active-high gate in parallel with a pmos with an active-low gate.
- Sequences the gate controls with break-before-make dead time, so no two sources ever drive the drain together.
- Enforces a maximum hold time per grant.

Parameters:
- N, 4, number of sources/requesters; 2 to 8.
- DEAD_CYCLES, 2, all-off cycles between releasing one gate pair and re-arbitrating; at least 1.
- MAX_HOLD, 8, maximum consecutive cycles one owner keeps its gate on; 0 disables the timeout.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  request per source; level, held while the source needs the drain.
- grant  output  N  one-hot or zero; the current owner.
- ngate  output  N  nmos gate controls; 1 = nmos on; always equal to grant.
- pgate  output  N  pmos gate controls; 0 = pmos on; always equal to ~ngate.
- busy  output  1  1 while any gate pair is on.
- owner  output  max(1,$clog2(N))  index of the last granted source; holds its value through DEAD and IDLE.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (rst_n=0, asynchronous, effective mid-cycle):
  - grant=0, ngate=0, pgate=all 1s, busy=0, owner=0, timeout=0.
  - State=IDLE, hold counter=0, dead counter=0.
  - Round-robin pointer set so source 0 has top priority.
  - Reset during ON turns gates off immediately, without waiting for a clock edge.
- Registered outputs: every output is a flop or a direct copy of one; no combinational path from req to any output.
- State IDLE:
  - All gates off.
  - If any req bit is 1 at an edge, select the first set bit searching from (owner+1) mod N upward, wrapping.
  - After reset the search starts at 0.
  - Next state ON; grant, ngate, pgate and busy reflect the winner from that edge, i.e. one cycle of latency from req.
- State ON:
  - Exactly one grant bit set; the hold counter increments every cycle in ON, starting at 1.
  - req[owner]=0 sampled: the edge clears the gates, next state DEAD, timeout stays 0.
  - MAX_HOLD>0, hold counter = MAX_HOLD, req[owner] still 1: the edge clears the gates, timeout=1 for exactly one cycle, next state DEAD.
  - The maximum ON duration is therefore MAX_HOLD cycles.
  - Requests from other sources are ignored while ON; there is no preemption.
- State DEAD:
  - All gates off, busy=0.
  - Stays exactly DEAD_CYCLES cycles, then IDLE.
  - Arbitration in IDLE adds one more cycle. Minimum gap between one owner's last on-cycle and the next owner's first on-cycle is DEAD_CYCLES+1 cycles.
- Fairness:
  - A timed-out source keeps requesting but ranks lowest in the next arbitration.
  - It is regranted only if no other source requests; that is legal and gets a new full MAX_HOLD.
- Boundaries:
  - A source whose req pulses for 1 cycle still gets a full ON cycle.
  - It then releases on the next edge, so it holds exactly 1 ON cycle.
  - If req[owner] drops in the same cycle the counter reaches MAX_HOLD, the release is treated as normal: timeout=0.
  - All req=0: remain in IDLE indefinitely.
  - N not a power of 2: the pointer wraps at N-1, never at a power of 2.
- Invariants, checked by assertions:
  - popcount(grant) is at most 1.
  - pgate equals ~ngate.
  - ngate is never nonzero within DEAD_CYCLES cycles after any gate falls.

Test Plan:
- Reset with req=4'b1111 held, then release rst_n: grant=4'b0001 one cycle after the first edge with rst_n=1; pgate=4'b1110.
- N=4, DEAD_CYCLES=2, MAX_HOLD=8, req=4'b1111 held:
  - Grants cycle 0001→0010→0100→1000→0001.
  - Each grant lasts 8 cycles with timeout pulsing at its end.
  - Gaps are 3 all-off cycles.
- req=4'b0100 only, held 3 cycles then dropped: grant=4'b0100 for 3 cycles; timeout=0; after 2 DEAD plus 1 IDLE cycle, busy=0 steady.
- Only source 2 requests, continuously: grant=4'b0100 for 8 cycles, timeout pulse, 3 off-cycles, then regranted for 8 more cycles.
- rst_n asserted mid-ON with grant=4'b0010: ngate=0 and pgate=4'b1111 within the same cycle, before the next clk edge; after release, priority restarts at source 0.
- Source 1 owns the drain and req switches to 4'b1001 as it releases: the next grant is 4'b1000 (source 3), because the search starts at owner+1=2.
